// File: rtl/lpc_sniffer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lpc_sniffer_pkg
//  Description : Shared types and constants for the LPC record-to-ASCII path.
//  Revision    : 1.0 - initial release
// ============================================================================
package lpc_sniffer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int LINE_LEN = 15;
    localparam int MARK_LEN = 3;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BANG  = 8'h21;

    localparam int CYC_LSB  = 0;
    localparam int CYC_MSB  = 3;
    localparam int DATA_LSB = 8;
    localparam int DATA_MSB = 15;
    localparam int ADDR_LSB = 16;
    localparam int ADDR_MSB = 47;

endpackage : lpc_sniffer_pkg
`default_nettype wire

// File: rtl/mem2ascii_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mem2ascii_if
//  Description : Ring-buffer read port and uart_tx byte port of mem2ascii.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem2ascii_if;

    logic        read_empty;
    logic        read_clock_enable;
    logic [47:0] read_data;
    logic        uart_ready;
    logic        uart_clock_enable;
    logic [7:0]  uart_data;
    logic        overflow;

    modport master (
        input  read_empty, read_data, uart_ready, overflow,
        output read_clock_enable, uart_clock_enable, uart_data
    );

    modport slave (
        output read_empty, read_data, uart_ready, overflow,
        input  read_clock_enable, uart_clock_enable, uart_data
    );

endinterface : mem2ascii_if
`default_nettype wire

// File: rtl/nibble2ascii.sv
`default_nettype none
// ============================================================================
//  Module      : nibble2ascii
//  Description : Combinational 4-bit nibble to ASCII hex digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble2ascii #(
    parameter bit UPPERCASE = 1'b1
) (
    input  wire logic [3:0] i_nibble,
    output logic      [7:0] o_ascii
);

    localparam logic [7:0] c_alpha_base = UPPERCASE ? 8'h41 : 8'h61;

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_ascii = 8'h30 + {4'h0, i_nibble};
        end else begin
            o_ascii = c_alpha_base + {4'h0, i_nibble} - 8'd10;
        end
    end

endmodule : nibble2ascii
`default_nettype wire

// File: rtl/mem2ascii.sv
`default_nettype none
// ============================================================================
//  Module      : mem2ascii
//  Description : Pops 48-bit LPC records and emits "C AAAAAAAA DD\r\n" lines.
//                Optional overflow marker line "!\r\n": MEM2ASCII_OVERFLOW_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem2ascii
    import lpc_sniffer_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  wire logic   clock,
    input  wire logic   reset,
    mem2ascii_if.master bus
);

    state_t      r_state,  w_state_next;
    logic [3:0]  r_idx,    w_idx_next;
    logic [47:0] r_rec,    w_rec_next;
    logic        r_rce,    w_rce_next;
    logic        r_uce,    w_uce_next;
    logic [7:0]  r_data,   w_data_next;
    logic [3:0]  w_nib;
    logic [7:0]  w_hex;
    logic [7:0]  w_char;
    logic [3:0]  w_last;
    logic [31:0] w_addr_sh;
    logic        w_unused_ok;

`ifdef MEM2ASCII_OVERFLOW_EN
    logic r_mark, w_mark_next;
    logic r_pend, r_ovf_prev, w_ovf_rise, w_pend_clr;

    assign w_ovf_rise  = bus.overflow & ~r_ovf_prev;
    assign w_last      = r_mark ? 4'(MARK_LEN - 1) : 4'(LINE_LEN - 1);
    assign w_unused_ok = ^r_rec[7:4];
`else
    assign w_last      = 4'(LINE_LEN - 1);
    assign w_unused_ok = ^{r_rec[7:4], bus.overflow};
`endif

    // Address digits walk MSB-first: index 2 selects bits [47:44].
    assign w_addr_sh = r_rec[ADDR_MSB:ADDR_LSB] << {r_idx - 4'd2, 2'b00};

    always_comb begin
        w_nib = r_rec[CYC_MSB:CYC_LSB];
        case (r_idx)
            4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd7, 4'd8, 4'd9: w_nib = w_addr_sh[31:28];
            4'd11:                  w_nib = r_rec[DATA_MSB:DATA_MSB-3];
            4'd12:                  w_nib = r_rec[DATA_LSB+3:DATA_LSB];
            default:                w_nib = r_rec[CYC_MSB:CYC_LSB];
        endcase
    end

    nibble2ascii #(.UPPERCASE(UPPERCASE)) u_nibble2ascii (
        .i_nibble (w_nib),
        .o_ascii  (w_hex)
    );

    always_comb begin
        w_char = w_hex;
        case (r_idx)
            4'd1, 4'd10: w_char = SPACE;
            4'd13:       w_char = CR;
            4'd14:       w_char = LF;
            default:     w_char = w_hex;
        endcase
`ifdef MEM2ASCII_OVERFLOW_EN
        if (r_mark) begin
            case (r_idx)
                4'd0:    w_char = BANG;
                4'd1:    w_char = CR;
                default: w_char = LF;
            endcase
        end
`endif
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_rec_next   = r_rec;
        w_rce_next   = 1'b0;
        w_uce_next   = 1'b0;
        w_data_next  = r_data;
`ifdef MEM2ASCII_OVERFLOW_EN
        w_mark_next  = r_mark;
        w_pend_clr   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
`ifdef MEM2ASCII_OVERFLOW_EN
                // Flag is cleared on acceptance so a rise during the marker re-arms it.
                if (r_pend) begin
                    w_mark_next  = 1'b1;
                    w_pend_clr   = 1'b1;
                    w_idx_next   = 4'd0;
                    w_state_next = SEND;
                end else if (!bus.read_empty) begin
                    w_mark_next  = 1'b0;
                    w_rce_next   = 1'b1;
                    w_state_next = FETCH;
                end
`else
                if (!bus.read_empty) begin
                    w_rce_next   = 1'b1;
                    w_state_next = FETCH;
                end
`endif
            end
            FETCH: w_state_next = LATCH;
            LATCH: begin
                w_rec_next   = bus.read_data;
                w_idx_next   = 4'd0;
                w_state_next = SEND;
            end
            SEND: begin
                if (bus.uart_ready) begin
                    w_data_next  = w_char;
                    w_uce_next   = 1'b1;
                    w_state_next = GAP;
                end
            end
            GAP: begin
                if (r_idx == w_last) begin
                    w_state_next = IDLE;
                end else begin
                    w_idx_next   = r_idx + 4'd1;
                    w_state_next = SEND;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= 4'd0;
            r_rec      <= 48'd0;
            r_rce      <= 1'b0;
            r_uce      <= 1'b0;
            r_data     <= 8'h00;
`ifdef MEM2ASCII_OVERFLOW_EN
            r_mark     <= 1'b0;
            r_pend     <= 1'b0;
            r_ovf_prev <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_rec      <= w_rec_next;
            r_rce      <= w_rce_next;
            r_uce      <= w_uce_next;
            r_data     <= w_data_next;
`ifdef MEM2ASCII_OVERFLOW_EN
            r_mark     <= w_mark_next;
            r_ovf_prev <= bus.overflow;
            if (w_ovf_rise) begin
                r_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend <= 1'b0;
            end
`endif
        end
    end

    assign bus.read_clock_enable = r_rce;
    assign bus.uart_clock_enable = r_uce;
    assign bus.uart_data         = r_data;

endmodule : mem2ascii
`default_nettype wire

// File: tb/tb_mem2ascii.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem2ascii
//  Description : Self-checking bench for mem2ascii (upper- and lower-case DUTs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem2ascii;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem2ascii_if bus ();
    mem2ascii_if bus_lc ();

    assign bus_lc.read_empty = bus.read_empty;
    assign bus_lc.read_data  = bus.read_data;
    assign bus_lc.uart_ready = bus.uart_ready;
    assign bus_lc.overflow   = bus.overflow;

    mem2ascii #(.UPPERCASE(1'b1)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    mem2ascii #(.UPPERCASE(1'b0)) u_dut_lc (
        .clock (clk),
        .reset (rst),
        .bus   (bus_lc.master)
    );

    int checks = 0;
    int errors = 0;
    int dbl    = 0;

    logic [47:0] ring[$];
    logic [7:0]  rx[$], rx_lc[$];
    logic [7:0]  exp_q[$], exp_lc[$];
    int          pop_at[$], exp_pop[$];
    bit          bp_mode  = 1'b0;
    bit          rnd_mode = 1'b0;
    string       up_digits = "0123456789ABCDEF";
    string       lo_digits = "0123456789abcdef";

    // Reference model: a line is just its characters, in order.
    function automatic void push_hex(logic [3:0] n);
        exp_q.push_back(up_digits[n]);
        exp_lc.push_back(lo_digits[n]);
    endfunction

    function automatic void push_ch(logic [7:0] c);
        exp_q.push_back(c);
        exp_lc.push_back(c);
    endfunction

    function automatic void push_line(logic [47:0] r);
        exp_pop.push_back(exp_q.size());
        push_hex(r[3:0]);
        push_ch(8'h20);
        for (int k = 7; k >= 0; k--) push_hex(r[16+4*k +: 4]);
        push_ch(8'h20);
        push_hex(r[15:12]);
        push_hex(r[11:8]);
        push_ch(8'h0D);
        push_ch(8'h0A);
    endfunction

    function automatic logic [47:0] rand_rec();
        return {16'($urandom), $urandom};
    endfunction

    // Ring buffer: data appears the cycle after the pop pulse, garbage otherwise.
    initial begin
        bus.read_empty = 1'b1;
        bus.read_data  = 48'd0;
        forever begin
            @(negedge clk);
            if (bus.read_clock_enable === 1'b1 && !rst) begin
                logic [47:0] r;
                r = (ring.size() != 0) ? ring.pop_front() : 48'hBAD0_BAD0_BAD0;
                pop_at.push_back(rx.size());
                bus.read_empty = (ring.size() == 0);
                @(posedge clk);
                #1 bus.read_data = r;
                @(posedge clk);
                #1 bus.read_data = rand_rec();
            end
            bus.read_empty = (ring.size() == 0);
        end
    end

    // Output monitor.
    initial begin
        bit pu, pr, pl;
        pu = 0; pr = 0; pl = 0;
        forever begin
            @(negedge clk);
            if (bus.uart_clock_enable === 1'b1) rx.push_back(bus.uart_data);
            if (bus_lc.uart_clock_enable === 1'b1) rx_lc.push_back(bus_lc.uart_data);
            if (bus.uart_clock_enable && pu) dbl++;
            if (bus.read_clock_enable && pr) dbl++;
            if (bus_lc.uart_clock_enable && pl) dbl++;
            pu = bus.uart_clock_enable;
            pr = bus.read_clock_enable;
            pl = bus_lc.uart_clock_enable;
        end
    end

    // uart_ready driver: always-ready, random, or 50-cycle backpressure per byte.
    initial begin
        bus.uart_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rnd_mode) begin
                bus.uart_ready = 1'($urandom_range(0, 1));
            end else if (bp_mode && bus.uart_clock_enable === 1'b1) begin
                logic [7:0] held;
                bit         stable;
                held   = bus.uart_data;
                stable = 1'b1;
                bus.uart_ready = 1'b0;
                repeat (50) begin
                    @(negedge clk);
                    if (bus.uart_data !== held || bus.uart_clock_enable !== 1'b0) stable = 1'b0;
                end
                checks++;
                assert (stable === 1'b1) else begin
                    errors++;
                    $error("FAIL bp_hold: uart_data/enable changed while not ready (held %02h, now %02h)", held, bus.uart_data);
                end
                bus.uart_ready = 1'b1;
            end else begin
                bus.uart_ready = 1'b1;
            end
        end
    end

    task automatic check_stream(string tag, int budget);
        int c;
        c = 0;
        while ((rx.size() < exp_q.size() || rx_lc.size() < exp_lc.size()) && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        assert (c < budget) else begin
            errors++;
            $error("FAIL %s_timeout: got %0d bytes, expected %0d", tag, rx.size(), exp_q.size());
        end
        repeat (60) @(negedge clk);
        checks++;
        assert (rx.size() == exp_q.size()) else begin
            errors++;
            $error("FAIL %s_count: got %0d bytes, expected %0d", tag, rx.size(), exp_q.size());
        end
        checks++;
        assert (rx_lc.size() == exp_lc.size()) else begin
            errors++;
            $error("FAIL %s_count_lc: got %0d bytes, expected %0d", tag, rx_lc.size(), exp_lc.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checks++;
            assert (rx[i] === exp_q[i]) else begin
                errors++;
                $error("FAIL %s_byte%0d: got %02h expected %02h", tag, i, rx[i], exp_q[i]);
            end
        end
        for (int i = 0; i < exp_lc.size() && i < rx_lc.size(); i++) begin
            checks++;
            assert (rx_lc[i] === exp_lc[i]) else begin
                errors++;
                $error("FAIL %s_lc_byte%0d: got %02h expected %02h", tag, i, rx_lc[i], exp_lc[i]);
            end
        end
        checks++;
        assert (pop_at.size() == exp_pop.size()) else begin
            errors++;
            $error("FAIL %s_pops: got %0d pops, expected %0d", tag, pop_at.size(), exp_pop.size());
        end
        for (int i = 0; i < exp_pop.size() && i < pop_at.size(); i++) begin
            checks++;
            assert (pop_at[i] == exp_pop[i]) else begin
                errors++;
                $error("FAIL %s_pop%0d_pos: popped after %0d bytes, expected after %0d", tag, i, pop_at[i], exp_pop[i]);
            end
        end
        rx.delete(); rx_lc.delete(); exp_q.delete(); exp_lc.delete();
        pop_at.delete(); exp_pop.delete();
    endtask

    task automatic check_idle_outputs(string tag);
        checks++;
        assert (bus.uart_data === 8'h00) else begin
            errors++; $error("FAIL %s_uart_data: got %02h expected 00", tag, bus.uart_data);
        end
        checks++;
        assert (bus.uart_clock_enable === 1'b0) else begin
            errors++; $error("FAIL %s_uart_ce: got %b expected 0", tag, bus.uart_clock_enable);
        end
        checks++;
        assert (bus.read_clock_enable === 1'b0) else begin
            errors++; $error("FAIL %s_read_ce: got %b expected 0", tag, bus.read_clock_enable);
        end
        checks++;
        assert (bus_lc.uart_data === 8'h00) else begin
            errors++; $error("FAIL %s_uart_data_lc: got %02h expected 00", tag, bus_lc.uart_data);
        end
    endtask

    initial begin
        logic [47:0] r, r2;
        int          c;
        bus.overflow = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single directed record
        r = {32'h1234ABCD, 8'h5E, 4'h0, 4'h2};
        push_line(r);
        ring.push_back(r);
        check_stream("single", 500);

        // Backpressure
        bp_mode = 1'b1;
        r = rand_rec();
        push_line(r);
        ring.push_back(r);
        check_stream("backpressure", 2000);
        bp_mode = 1'b0;

        // Back-to-back records, second one all-F address
        r  = rand_rec();
        r2 = {32'hFFFFFFFF, 8'h00, 4'($urandom), 4'hF};
        push_line(r);
        push_line(r2);
        ring.push_back(r);
        ring.push_back(r2);
        check_stream("b2b", 500);

        // Random records under random uart_ready
        rnd_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            r = rand_rec();
            push_line(r);
            ring.push_back(r);
        end
        check_stream("random", 4000);
        rnd_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Overflow rise with a record pending
        bus.overflow = 1'b1;
        repeat (2) @(negedge clk);
        r = rand_rec();
`ifdef MEM2ASCII_OVERFLOW_EN
        push_ch(8'h21);
        push_ch(8'h0D);
        push_ch(8'h0A);
`endif
        push_line(r);
        ring.push_back(r);
        check_stream("overflow", 500);
        bus.overflow = 1'b0;

        // Reset mid-line after the fifth byte
        r = rand_rec();
        ring.push_back(r);
        c = 0;
        while (rx.size() < 5 && c < 500) begin
            @(negedge clk);
            c++;
        end
        checks++;
        assert (c < 500) else begin
            errors++; $error("FAIL midreset_timeout: got %0d bytes expected 5", rx.size());
        end
        #2 rst = 1'b1;
        #1 check_idle_outputs("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        checks++;
        assert (rx.size() == 5) else begin
            errors++; $error("FAIL midreset_bytes: got %0d bytes expected 5", rx.size());
        end
        checks++;
        assert (pop_at.size() == 1) else begin
            errors++; $error("FAIL midreset_pops: got %0d pops expected 1", pop_at.size());
        end

        checks++;
        assert (dbl == 0) else begin
            errors++; $error("FAIL pulse_width: got %0d double-width pulses expected 0", dbl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem2ascii
`default_nettype wire
